// File: rtl/wb_merge_queue.sv
// Write-back merge queue: accepts a load and an ALU result per cycle in program
// order and drains one register-file write per cycle, with youngest-match forwarding.
module wb_merge_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_mem_valid,
    input  logic [ADDR_WIDTH-1:0]      i_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    input  logic                       i_alu_valid,
    input  logic [ADDR_WIDTH-1:0]      i_alu_addr,
    input  logic [DATA_WIDTH-1:0]      i_alu_data,
    output logic                       o_ready,
    output logic                       o_wb_uses_rw,
    output logic [ADDR_WIDTH-1:0]      o_wb_rw_addr,
    output logic [DATA_WIDTH-1:0]      o_wb_rw_data,
    input  logic [ADDR_WIDTH-1:0]      i_fwd_rs_addr,
    output logic                       o_fwd_rs_hit,
    output logic [DATA_WIDTH-1:0]      o_fwd_rs_data,
    input  logic [ADDR_WIDTH-1:0]      i_fwd_rt_addr,
    output logic                       o_fwd_rt_hit,
    output logic [DATA_WIDTH-1:0]      o_fwd_rt_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] entry_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] entry_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  ready;
    logic                  mem_push, alu_push, pop;
    logic [1:0]            pushes;
    logic [PW-1:0]         alu_slot;

    always_comb begin
        ready    = (count_q <= CW'(DEPTH - 2));
        // Register 0 is hard-wired, so writes to it never take a slot.
        mem_push = ready && i_mem_valid && (i_mem_addr != '0);
        alu_push = ready && i_alu_valid && (i_alu_addr != '0);
        pop      = (count_q != '0);
        pushes   = {1'b0, mem_push} + {1'b0, alu_push};
        alu_slot = mem_push ? tail_q + PW'(1) : tail_q;

        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        if (mem_push) begin
            entry_addr_d[tail_q] = i_mem_addr;
            entry_data_d[tail_q] = i_mem_data;
        end
        if (alu_push) begin
            entry_addr_d[alu_slot] = i_alu_addr;
            entry_data_d[alu_slot] = i_alu_data;
        end

        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = tail_q + PW'(pushes);
        count_d = count_q + CW'(pushes) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only meaningful while count_q covers it.
    always_ff @(posedge clk) begin
        entry_addr_q <= entry_addr_d;
        entry_data_q <= entry_data_d;
    end

    // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH:0] result;
        logic [PW-1:0]       idx;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr != '0) && (entry_addr_q[idx] == addr))
                result = {1'b1, entry_data_q[idx]};
        end
        return result;
    endfunction

    always_comb begin
        {o_fwd_rs_hit, o_fwd_rs_data} = fwd_lookup(i_fwd_rs_addr);
        {o_fwd_rt_hit, o_fwd_rt_data} = fwd_lookup(i_fwd_rt_addr);
    end

    assign o_ready      = ready;
    assign o_count      = count_q;
    assign o_wb_uses_rw = pop;
    assign o_wb_rw_addr = pop ? entry_addr_q[head_q] : '0;
    assign o_wb_rw_data = pop ? entry_data_q[head_q] : '0;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !ready |-> !(i_mem_valid || i_alu_valid)
    );

endmodule

// File: tb/tb_wb_merge_queue.sv
// Bench for wb_merge_queue: vector table for single-cycle behaviour plus
// hand-written fill/drain and asynchronous-reset sequences.
module tb_wb_merge_queue;
    logic        clk, rst_n;
    logic        i_mem_valid, i_alu_valid;
    logic [4:0]  i_mem_addr, i_alu_addr, i_fwd_rs_addr, i_fwd_rt_addr;
    logic [31:0] i_mem_data, i_alu_data;
    logic        o_ready, o_wb_uses_rw, o_fwd_rs_hit, o_fwd_rt_hit;
    logic [4:0]  o_wb_rw_addr;
    logic [31:0] o_wb_rw_data, o_fwd_rs_data, o_fwd_rt_data;
    logic [2:0]  o_count;

    int checks = 0;
    int errors = 0;

    wb_merge_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_valid(i_mem_valid), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .i_alu_valid(i_alu_valid), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .o_ready(o_ready), .o_wb_uses_rw(o_wb_uses_rw),
        .o_wb_rw_addr(o_wb_rw_addr), .o_wb_rw_data(o_wb_rw_data),
        .i_fwd_rs_addr(i_fwd_rs_addr), .o_fwd_rs_hit(o_fwd_rs_hit), .o_fwd_rs_data(o_fwd_rs_data),
        .i_fwd_rt_addr(i_fwd_rt_addr), .o_fwd_rt_hit(o_fwd_rt_hit), .o_fwd_rt_data(o_fwd_rt_data),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        i_mem_valid = mv; i_mem_addr = ma; i_mem_data = md;
        i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    endtask

    typedef struct {
        logic        mv;  logic [4:0] ma; logic [31:0] md;
        logic        av;  logic [4:0] aa; logic [31:0] ad;
        logic [4:0]  rs;  logic [4:0] rt;
        logic        e_ready; logic e_uses; logic [4:0] e_addr; logic [31:0] e_data;
        logic        e_rs_hit; logic [31:0] e_rs_data;
        logic        e_rt_hit; logic [31:0] e_rt_data;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs [16];

    logic [4:0]  m_addr [$];
    logic [31:0] m_data [$];
    logic [4:0]  obs_addr [$];
    logic [31:0] obs_data [$];

    initial begin
        // Each row: inputs driven this cycle, outputs expected during this cycle (before the accepting edge).
        vecs[0]  = '{0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[1]  = '{0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[2]  = '{0,0,0, 1,5,32'h0000_1234, 5,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[3]  = '{0,0,0, 0,0,0, 5,0, 1,1,5,32'h0000_1234, 1,32'h0000_1234, 0,0, 1};
        vecs[4]  = '{0,0,0, 0,0,0, 5,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[5]  = '{1,3,32'hAAAA_0001, 1,3,32'hBBBB_0002, 3,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[6]  = '{0,0,0, 0,0,0, 3,3, 1,1,3,32'hAAAA_0001, 1,32'hBBBB_0002, 1,32'hBBBB_0002, 2};
        vecs[7]  = '{0,0,0, 0,0,0, 3,0, 1,1,3,32'hBBBB_0002, 1,32'hBBBB_0002, 0,0, 1};
        vecs[8]  = '{0,0,0, 0,0,0, 3,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[9]  = '{1,0,32'hFFFF_FFFF, 1,0,32'h0000_0001, 0,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[10] = '{0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0, 0,0, 0};
        vecs[11] = '{1,7,32'h0000_0077, 0,0,0, 7,9, 1,0,0,0, 0,0, 0,0, 0};
        vecs[12] = '{1,7,32'h0000_7777, 1,9,32'h0000_0099, 7,9, 1,1,7,32'h0000_0077, 1,32'h0000_0077, 0,0, 1};
        vecs[13] = '{0,0,0, 0,0,0, 7,9, 1,1,7,32'h0000_7777, 1,32'h0000_7777, 1,32'h0000_0099, 2};
        vecs[14] = '{0,0,0, 0,0,0, 7,9, 1,1,9,32'h0000_0099, 0,0, 1,32'h0000_0099, 1};
        vecs[15] = '{0,0,0, 0,0,0, 7,9, 1,0,0,0, 0,0, 0,0, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        i_fwd_rs_addr = '0;
        i_fwd_rt_addr = '0;
        #1;
        check("reset ready", 32'(o_ready), 32'd1);
        check("reset count", 32'(o_count), 32'd0);
        check("reset uses_rw", 32'(o_wb_uses_rw), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].av, vecs[i].aa, vecs[i].ad);
            i_fwd_rs_addr = vecs[i].rs;
            i_fwd_rt_addr = vecs[i].rt;
            #1;
            check($sformatf("v%0d ready", i),   32'(o_ready),       32'(vecs[i].e_ready));
            check($sformatf("v%0d uses", i),    32'(o_wb_uses_rw),  32'(vecs[i].e_uses));
            check($sformatf("v%0d wb_addr", i), 32'(o_wb_rw_addr),  32'(vecs[i].e_addr));
            check($sformatf("v%0d wb_data", i), o_wb_rw_data,       vecs[i].e_data);
            check($sformatf("v%0d rs_hit", i),  32'(o_fwd_rs_hit),  32'(vecs[i].e_rs_hit));
            check($sformatf("v%0d rs_data", i), o_fwd_rs_data,      vecs[i].e_rs_data);
            check($sformatf("v%0d rt_hit", i),  32'(o_fwd_rt_hit),  32'(vecs[i].e_rt_hit));
            check($sformatf("v%0d rt_data", i), o_fwd_rt_data,      vecs[i].e_rt_data);
            check($sformatf("v%0d count", i),   32'(o_count),       32'(vecs[i].e_count));
        end

        // Fill/drain: dual pushes r1..r8 whenever the queue can take them.
        begin
            int  next_k;
            bit  saw_not_ready;
            bit  push;
            next_k = 1;
            saw_not_ready = 0;
            i_fwd_rs_addr = '0;
            i_fwd_rt_addr = '0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (next_k > 8 && m_addr.size() == 0) break;
                @(negedge clk);
                push = (m_addr.size() <= 2) && (next_k <= 8);
                if (push)
                    drive(1, 5'(next_k), 32'h100 + 32'(next_k), 1, 5'(next_k + 1), 32'h100 + 32'(next_k + 1));
                else
                    drive(0, 0, 0, 0, 0, 0);
                #1;
                check($sformatf("fill c%0d ready", cyc), 32'(o_ready), 32'(m_addr.size() <= 2));
                check($sformatf("fill c%0d count", cyc), 32'(o_count), 32'(m_addr.size()));
                check($sformatf("fill c%0d uses", cyc),  32'(o_wb_uses_rw), 32'(m_addr.size() != 0));
                if (!o_ready) saw_not_ready = 1;
                if (o_wb_uses_rw) begin
                    obs_addr.push_back(o_wb_rw_addr);
                    obs_data.push_back(o_wb_rw_data);
                end
                if (m_addr.size() != 0) begin
                    check($sformatf("fill c%0d wb_addr", cyc), 32'(o_wb_rw_addr), 32'(m_addr[0]));
                    check($sformatf("fill c%0d wb_data", cyc), o_wb_rw_data, m_data[0]);
                    void'(m_addr.pop_front());
                    void'(m_data.pop_front());
                end
                if (push) begin
                    m_addr.push_back(5'(next_k));     m_data.push_back(32'h100 + 32'(next_k));
                    m_addr.push_back(5'(next_k + 1)); m_data.push_back(32'h100 + 32'(next_k + 1));
                    next_k += 2;
                end
            end
            check("fill saw ready low", 32'(saw_not_ready), 32'd1);
            check("fill writes seen", 32'(obs_addr.size()), 32'd8);
            for (int j = 0; j < obs_addr.size() && j < 8; j++) begin
                check($sformatf("fill order %0d addr", j), 32'(obs_addr[j]), 32'(j + 1));
                check($sformatf("fill order %0d data", j), obs_data[j], 32'h100 + 32'(j + 1));
            end
        end

        // Asynchronous reset with three entries queued.
        @(negedge clk);
        drive(1, 10, 32'h0000_0A10, 1, 11, 32'h0000_0A11);
        @(negedge clk);
        drive(1, 12, 32'h0000_0A12, 1, 13, 32'h0000_0A13);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        i_fwd_rs_addr = 5'd12;
        #1;
        check("pre-reset count", 32'(o_count), 32'd3);
        check("pre-reset wb_addr", 32'(o_wb_rw_addr), 32'd11);
        check("pre-reset rs_hit", 32'(o_fwd_rs_hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst uses", 32'(o_wb_uses_rw), 32'd0);
        check("async rst wb_addr", 32'(o_wb_rw_addr), 32'd0);
        check("async rst wb_data", o_wb_rw_data, 32'd0);
        check("async rst count", 32'(o_count), 32'd0);
        check("async rst ready", 32'(o_ready), 32'd1);
        check("async rst rs_hit", 32'(o_fwd_rs_hit), 32'd0);
        check("async rst rs_data", o_fwd_rs_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-rst c%0d uses", c), 32'(o_wb_uses_rw), 32'd0);
            check($sformatf("post-rst c%0d count", c), 32'(o_count), 32'd0);
            check($sformatf("post-rst c%0d rs_hit", c), 32'(o_fwd_rs_hit), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
